// File: rtl/scanline_mixer.sv
// Video output stage: expands pixel-rate RGB to 8 bits and darkens selected lines
// of a programmable 1..SL_PERIOD_MAX line pattern, with optional per-frame phase flip.
module scanline_mixer #(
  parameter int DW            = 8,
  parameter int SL_PERIOD_MAX = 4,
  parameter int BLANK_BLACK   = 1,
  localparam int LW           = $clog2(SL_PERIOD_MAX)
) (
  input  logic                     clk_vid,
  input  logic                     reset,
  input  logic                     ce_pix,
  input  logic [DW-1:0]            R,
  input  logic [DW-1:0]            G,
  input  logic [DW-1:0]            B,
  input  logic                     mono,
  input  logic                     HSync,
  input  logic                     VSync,
  input  logic                     HBlank,
  input  logic                     VBlank,
  input  logic [3:0]               sl_level,
  input  logic [SL_PERIOD_MAX-1:0] sl_mask,
  input  logic [LW-1:0]            sl_len,
  input  logic                     sl_alternate,
  output logic                     ce_pix_out,
  output logic [7:0]               VGA_R,
  output logic [7:0]               VGA_G,
  output logic [7:0]               VGA_B,
  output logic                     VGA_HS,
  output logic                     VGA_VS,
  output logic                     VGA_DE
);

  logic [2:0][7:0] exp_rgb;

  generate
    if (DW == 8) begin : g_full
      logic unused_mono;
      assign unused_mono = mono;
      assign exp_rgb[0] = R;
      assign exp_rgb[1] = G;
      assign exp_rgb[2] = B;
    end else if (DW == 4) begin : g_four
      assign exp_rgb[0] = mono ? {G, R} : {R, R};
      assign exp_rgb[1] = mono ? {G, R} : {G, G};
      assign exp_rgb[2] = mono ? {G, R} : {B, B};
    end else begin : g_rep
      logic unused_mono;
      assign unused_mono = mono;
      assign exp_rgb[0] = {R, R[DW-1 -: 8-DW]};
      assign exp_rgb[1] = {G, G[DW-1 -: 8-DW]};
      assign exp_rgb[2] = {B, B[DW-1 -: 8-DW]};
    end
  endgenerate

  // Line/frame tracking and per-frame configuration
  logic                     old_hs_reg, old_vs_reg, frame_par_reg;
  logic [LW-1:0]            line_idx_reg, cfg_len_reg;
  logic [3:0]               cfg_level_reg;
  logic [SL_PERIOD_MAX-1:0] cfg_mask_reg;
  logic                     vsf, hsf;

  assign vsf = old_vs_reg & ~VSync;
  assign hsf = old_hs_reg & ~HSync;

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      old_hs_reg    <= 1'b0;
      old_vs_reg    <= 1'b0;
      frame_par_reg <= 1'b0;
      line_idx_reg  <= '0;
      cfg_len_reg   <= '0;
      cfg_level_reg <= '0;
      cfg_mask_reg  <= '0;
    end else begin
      old_hs_reg <= HSync;
      old_vs_reg <= VSync;
      if (vsf) begin
        cfg_len_reg   <= sl_len;
        cfg_level_reg <= sl_level;
        cfg_mask_reg  <= sl_mask;
        frame_par_reg <= ~frame_par_reg;
        // New parity is ~frame_par_reg; odd frames start one line into the pattern
        line_idx_reg  <= (sl_alternate && !frame_par_reg && sl_len != '0) ? LW'(1) : '0;
      end else if (hsf) begin
        line_idx_reg <= (line_idx_reg == cfg_len_reg) ? '0 : line_idx_reg + 1'b1;
      end
    end
  end

  // Stage 1
  logic [2:0][7:0] s1_rgb_reg;
  logic            s1_hs_reg, s1_vs_reg, s1_ce_reg, s1_hde_reg, s1_vde_reg;
  logic            s1_dim_reg, s1_valid_reg;
  logic [3:0]      s1_level_reg;

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      s1_rgb_reg   <= '0;
      s1_hs_reg    <= 1'b0;
      s1_vs_reg    <= 1'b0;
      s1_ce_reg    <= 1'b0;
      s1_hde_reg   <= 1'b0;
      s1_vde_reg   <= 1'b0;
      s1_dim_reg   <= 1'b0;
      s1_valid_reg <= 1'b0;
      s1_level_reg <= '0;
    end else begin
      s1_rgb_reg   <= exp_rgb;
      s1_hs_reg    <= HSync;
      s1_vs_reg    <= VSync;
      s1_ce_reg    <= ce_pix;
      s1_hde_reg   <= ~HBlank;
      s1_vde_reg   <= ~VBlank;
      s1_dim_reg   <= cfg_mask_reg[line_idx_reg] && (cfg_level_reg != 4'd0);
      s1_valid_reg <= 1'b1;
      s1_level_reg <= cfg_level_reg;
    end
  end

  // Stage 2: DE edge logic; de_armed_reg keeps the reset-cleared stage 1 from faking an hde rise
  logic            hde_prev_reg, de_armed_reg;
  logic            de_next;
  logic [4:0]      scale;
  logic [2:0][7:0] rgb_next;

  always_comb begin
    de_next = VGA_DE;
    if (s1_hde_reg && !hde_prev_reg && de_armed_reg) begin
      de_next = s1_vde_reg;
    end else if (!s1_hde_reg && hde_prev_reg) begin
      de_next = 1'b0;
    end
  end

  assign scale = 5'd16 - {1'b0, s1_level_reg};

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_chan
      logic [11:0] prod;
      logic [7:0]  dimmed;
      assign prod         = 12'(s1_rgb_reg[gi]) * 12'(scale);
      assign dimmed       = s1_dim_reg ? 8'(prod >> 4) : s1_rgb_reg[gi];
      assign rgb_next[gi] = (BLANK_BLACK != 0 && !de_next) ? 8'd0 : dimmed;
    end
  endgenerate

  always_ff @(posedge clk_vid or posedge reset) begin
    if (reset) begin
      VGA_R        <= '0;
      VGA_G        <= '0;
      VGA_B        <= '0;
      VGA_HS       <= 1'b0;
      VGA_VS       <= 1'b0;
      VGA_DE       <= 1'b0;
      ce_pix_out   <= 1'b0;
      hde_prev_reg <= 1'b0;
      de_armed_reg <= 1'b0;
    end else begin
      VGA_R        <= rgb_next[0];
      VGA_G        <= rgb_next[1];
      VGA_B        <= rgb_next[2];
      VGA_HS       <= s1_hs_reg;
      VGA_VS       <= s1_vs_reg;
      VGA_DE       <= de_next;
      ce_pix_out   <= s1_ce_reg;
      hde_prev_reg <= s1_hde_reg;
      de_armed_reg <= de_armed_reg | (s1_valid_reg & ~s1_hde_reg);
    end
  end

endmodule

// File: tb/tb_scanline_mixer.sv
// Directed bench for scanline_mixer: per-frame vector table plus hand sequences for
// latency, alternation, same-cycle sync edges, DW=4 expansion and mid-line reset.
module tb_scanline_mixer;

  logic       clk_vid = 1'b0;
  logic       reset;
  logic       ce_pix, mono, HSync, VSync, HBlank, VBlank, sl_alternate;
  logic [7:0] R, G, B;
  logic [3:0] sl_level, sl_mask;
  logic [1:0] sl_len;
  logic       ce_pix_out, VGA_HS, VGA_VS, VGA_DE;
  logic [7:0] VGA_R, VGA_G, VGA_B;

  logic [3:0] r4, g4, b4;
  logic       mono4;
  logic       ce_pix_out4, VGA_HS4, VGA_VS4, VGA_DE4;
  logic [7:0] VGA_R4, VGA_G4, VGA_B4;

  always #5 clk_vid = ~clk_vid;

  scanline_mixer #(.DW(8), .SL_PERIOD_MAX(4), .BLANK_BLACK(1)) dut (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
    .R(R), .G(G), .B(B), .mono(mono),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .sl_level(sl_level), .sl_mask(sl_mask), .sl_len(sl_len), .sl_alternate(sl_alternate),
    .ce_pix_out(ce_pix_out), .VGA_R(VGA_R), .VGA_G(VGA_G), .VGA_B(VGA_B),
    .VGA_HS(VGA_HS), .VGA_VS(VGA_VS), .VGA_DE(VGA_DE)
  );

  scanline_mixer #(.DW(4), .SL_PERIOD_MAX(4), .BLANK_BLACK(1)) dut4 (
    .clk_vid(clk_vid), .reset(reset), .ce_pix(ce_pix),
    .R(r4), .G(g4), .B(b4), .mono(mono4),
    .HSync(HSync), .VSync(VSync), .HBlank(HBlank), .VBlank(VBlank),
    .sl_level(4'd0), .sl_mask(sl_mask), .sl_len(sl_len), .sl_alternate(sl_alternate),
    .ce_pix_out(ce_pix_out4), .VGA_R(VGA_R4), .VGA_G(VGA_G4), .VGA_B(VGA_B4),
    .VGA_HS(VGA_HS4), .VGA_VS(VGA_VS4), .VGA_DE(VGA_DE4)
  );

  int checks   = 0;
  int failures = 0;
  int tb_par   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_vid);
    #1;
  endtask

  // Frame start; with_hs makes HSync fall on the same cycle as VSync
  task automatic vsync(input bit with_hs);
    HBlank = 1'b1; VBlank = 1'b1; VSync = 1'b1; HSync = with_hs;
    tick(); tick();
    check("vs_latency", VGA_VS, 1);
    VSync = 1'b0; HSync = 1'b0;
    tb_par ^= 1;
    tick(); tick(); tick();
    VBlank = 1'b0;
  endtask

  // One line: active period checked, then blanking with the HSync pulse at its end
  task automatic line(input string tag, input logic [7:0] exp_r);
    HBlank = 1'b0;
    repeat (5) tick();
    check({tag, "_de"}, VGA_DE, 1);
    check({tag, "_r"}, VGA_R, exp_r);
    HBlank = 1'b1;
    tick();
    HSync = 1'b1;
    tick(); tick();
    check({tag, "_hs"}, VGA_HS, 1);
    check({tag, "_blank_r"}, VGA_R, 0);
    HSync = 1'b0;
    tick(); tick();
  endtask

  typedef struct packed {
    logic [3:0]      level;
    logic [3:0]      mask;
    logic [1:0]      len;
    logic [7:0]      r;
    logic [5:0][7:0] exp;   // written line 0 first, so line k is exp[5-k]
  } vec_t;

  vec_t vecs [8];
  int   start;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{4'd8,  4'b0010, 2'd1, 8'hC8, {8'hC8, 8'h64, 8'hC8, 8'h64, 8'hC8, 8'h64}};
    vecs[1] = '{4'd4,  4'b0010, 2'd1, 8'hC8, {8'hC8, 8'h96, 8'hC8, 8'h96, 8'hC8, 8'h96}};
    vecs[2] = '{4'd15, 4'b0010, 2'd1, 8'hC8, {8'hC8, 8'h0C, 8'hC8, 8'h0C, 8'hC8, 8'h0C}};
    vecs[3] = '{4'd0,  4'b0010, 2'd1, 8'hC8, {8'hC8, 8'hC8, 8'hC8, 8'hC8, 8'hC8, 8'hC8}};
    vecs[4] = '{4'd8,  4'b0100, 2'd2, 8'hC8, {8'hC8, 8'hC8, 8'h64, 8'hC8, 8'hC8, 8'h64}};
    vecs[5] = '{4'd8,  4'b0001, 2'd0, 8'hC8, {8'h64, 8'h64, 8'h64, 8'h64, 8'h64, 8'h64}};
    vecs[6] = '{4'd8,  4'b0000, 2'd0, 8'hC8, {8'hC8, 8'hC8, 8'hC8, 8'hC8, 8'hC8, 8'hC8}};
    vecs[7] = '{4'd12, 4'b1001, 2'd3, 8'hC8, {8'h32, 8'hC8, 8'hC8, 8'h32, 8'h32, 8'hC8}};

    reset = 1'b1; ce_pix = 0; mono = 0; HSync = 0; VSync = 0; HBlank = 1; VBlank = 0;
    R = 8'hC8; G = 8'h40; B = 8'h20; r4 = 0; g4 = 0; b4 = 0; mono4 = 0;
    sl_level = 4'd8; sl_mask = 4'b1111; sl_len = 2'd0; sl_alternate = 0;
    tick(); tick();
    check("reset_outputs", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, ce_pix_out}, 0);
    reset = 1'b0;
    tick(); tick(); tick();
    // Config latched as zero: no dimming before the first VSync falling edge
    HBlank = 1'b0;
    repeat (3) tick();
    check("predim_de", VGA_DE, 1);
    check("predim_r", VGA_R, 8'hC8);
    check("predim_g", VGA_G, 8'h40);
    $display("reset/pre-vsf: checks=%0d failures=%0d", checks, failures);

    for (int v = 0; v < 8; v++) begin
      sl_level = vecs[v].level; sl_mask = vecs[v].mask; sl_len = vecs[v].len; R = vecs[v].r;
      sl_alternate = 1'b0;
      vsync(1'b0);
      for (int k = 0; k < 6; k++)
        line($sformatf("vec%0d_line%0d", v, k), vecs[v].exp[5-k]);
      $display("vec %0d level=%0d mask=%b len=%0d failures=%0d", v, vecs[v].level,
               vecs[v].mask, vecs[v].len, failures);
    end

    // Two-cycle latency for colour and ce_pix on an undimmed line
    sl_level = 4'd8; sl_mask = 4'b0010; sl_len = 2'd1;
    vsync(1'b0);
    HBlank = 1'b0;
    repeat (4) tick();
    R = 8'h10; ce_pix = 1'b1;
    tick();
    check("lat_r_1", VGA_R, 8'hC8);
    check("lat_ce_1", ce_pix_out, 0);
    ce_pix = 1'b0;
    tick();
    check("lat_r_2", VGA_R, 8'h10);
    check("lat_ce_2", ce_pix_out, 1);
    tick();
    check("lat_ce_3", ce_pix_out, 0);
    R = 8'hC8;
    HBlank = 1'b1; tick(); HSync = 1'b1; tick(); HSync = 1'b0; tick(); tick();
    $display("latency: failures=%0d", failures);

    // Alternation: start phase follows frame parity; mid-frame config change is ignored
    sl_alternate = 1'b1; sl_len = 2'd1; sl_mask = 4'b0010; sl_level = 4'd8;
    vsync(1'b0);
    start = tb_par;
    line("altA_l0", (start % 2) ? 8'h64 : 8'hC8);
    line("altA_l1", ((start + 1) % 2) ? 8'h64 : 8'hC8);
    vsync(1'b0);
    start = tb_par;
    line("altB_l0", (start % 2) ? 8'h64 : 8'hC8);
    line("altB_l1", ((start + 1) % 2) ? 8'h64 : 8'hC8);
    sl_mask = 4'b0001; sl_level = 4'd15; sl_alternate = 1'b0;
    line("altB_l2", (start % 2) ? 8'h64 : 8'hC8);
    line("altB_l3", ((start + 1) % 2) ? 8'h64 : 8'hC8);
    vsync(1'b0);
    line("newcfg_l0", 8'h0C);
    line("newcfg_l1", 8'hC8);
    $display("alternation: failures=%0d", failures);

    // HSync and VSync falling together: line index starts at 0, not 1
    sl_level = 4'd8; sl_mask = 4'b0100; sl_len = 2'd2;
    vsync(1'b1);
    line("same_l0", 8'hC8);
    line("same_l1", 8'hC8);
    line("same_l2", 8'h64);
    line("same_l3", 8'hC8);
    $display("same-cycle edges: failures=%0d", failures);

    // DW=4 expansion and mono
    HBlank = 1'b0;
    repeat (4) tick();
    r4 = 4'hA; g4 = 4'h5; b4 = 4'h3; mono4 = 1'b0;
    tick(); tick();
    check("dw4_de", VGA_DE4, 1);
    check("dw4_r", VGA_R4, 8'hAA);
    check("dw4_g", VGA_G4, 8'h55);
    check("dw4_b", VGA_B4, 8'h33);
    r4 = 4'hC; g4 = 4'h3; mono4 = 1'b1;
    tick(); tick();
    check("mono_r", VGA_R4, 8'h3C);
    check("mono_g", VGA_G4, 8'h3C);
    check("mono_b", VGA_B4, 8'h3C);
    HBlank = 1'b1; tick(); HSync = 1'b1; tick(); HSync = 1'b0; tick(); tick();
    $display("dw4: failures=%0d", failures);

    // Mid-line reset on a dimmed line
    sl_level = 4'd8; sl_mask = 4'b1111; sl_len = 2'd0;
    vsync(1'b0);
    HBlank = 1'b0; ce_pix = 1'b1;
    repeat (4) tick();
    check("prereset_de", VGA_DE, 1);
    check("prereset_r", VGA_R, 8'h64);
    #2;
    reset = 1'b1;
    #1;
    check("async_reset", {VGA_R, VGA_G, VGA_B, VGA_HS, VGA_VS, VGA_DE, ce_pix_out}, 0);
    tb_par = 0;
    tick();
    reset = 1'b0; ce_pix = 1'b0;
    repeat (4) tick();
    check("postreset_de", VGA_DE, 0);
    check("postreset_r", VGA_R, 0);
    HBlank = 1'b1;
    tick(); tick();
    check("postreset_blank_de", VGA_DE, 0);
    HBlank = 1'b0;
    tick();
    check("postreset_rise_1", VGA_DE, 0);
    tick();
    check("postreset_rise_2", VGA_DE, 1);
    check("postreset_nodim", VGA_R, 8'hC8);
    $display("reset mid-line: failures=%0d", failures);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/scanline_mixer.md
Name: scanline_mixer

Overview:
Parametrised successor to the existing video mixer output stage. It takes pixel-rate RGB plus sync/blank from the scandoubler or core and produces 8-bit VGA RGB/HS/VS/DE. Scanline darkening is generalised from a fixed 2-line pattern with three fixed levels to:
- a programmable 1..SL_PERIOD_MAX line pattern;
- a 16-step attenuation level;
- per-frame phase alternation for interlace.

It sits directly before the video output/scaler interface.

Parameters:
DW, 8, input bits per colour channel; legal values 4..8.
SL_PERIOD_MAX, 4, maximum scanline pattern period in lines; power of 2, at least 2. LW = log2(SL_PERIOD_MAX).
BLANK_BLACK, 1, when 1, RGB is forced to 0 whenever the output DE is 0.

Ports:
clk_vid  in  1  video clock.
reset  in  1  asynchronous, active-high reset.
ce_pix  in  1  pixel clock enable; delayed to ce_pix_out.
R, G, B  in  DW each  input colour.
mono  in  1  DW==4 only: output {G,R} on all three channels; ignored otherwise.
HSync, VSync, HBlank, VBlank  in  1 each  positive-pulse sync/blank.
sl_level  in  4  attenuation on darkened lines; 0 = off.
sl_mask  in  SL_PERIOD_MAX  bit i=1 darkens pattern line i.
sl_len  in  LW  pattern period minus 1.
sl_alternate  in  1  flip the pattern phase on each frame.
ce_pix_out  out  1  ce_pix delayed 2 cycles.
VGA_R, VGA_G, VGA_B  out  8 each  output colour.
VGA_HS, VGA_VS, VGA_DE  out  1 each  output sync and data enable.

Behaviour:
- Reset (asynchronous): all outputs 0. Pipeline, line index, frame parity and latched config all 0. With latched config 0, no dimming until the first VSync falling edge.
- Stages update on every clk_vid edge; they are not gated by ce_pix.
- Expansion, combinational before stage 1:
  - DW<8: each channel is its bits replicated MSB-first to 8 bits (e.g. DW=5, x → {x, x[4:2]}).
  - DW==4 with mono=1: all channels = {G,R}.
- Edge detection: old_hs/old_vs are registered copies of HSync/VSync.
  - VSync falling edge (vsf):
    - latch sl_level, sl_mask, sl_len and sl_alternate into cfg_*;
    - toggle frame_par;
    - set line_idx = (cfg_alt_new && frame_par_new && len_new != 0) ? 1 : 0, using the newly latched values.
  - HSync falling edge without vsf: line_idx = (line_idx == cfg_len) ? 0 : line_idx + 1.
  - Both on the same cycle: vsf wins.
- Config inputs changing mid-frame have no effect until the next vsf.
- Stage 1 registers:
  - expanded RGB, HSync, VSync, ce_pix;
  - hde = ~HBlank, vde = ~VBlank;
  - dim = cfg_mask[line_idx] && cfg_level != 0.
- Stage 2 colour and syncs:
  - if dim: c_out = (c × (16 − cfg_level)) >> 4, using a 12-bit product and truncating (level 15 gives c/16);
  - otherwise c_out = c;
  - VGA_HS, VGA_VS and ce_pix_out come from stage 1.
- Latency: exactly 2 clk_vid cycles from input to output for colour, syncs and ce_pix.
- DE, stage 2:
  - on a stage-1 hde rising edge, VGA_DE <= stage-1 vde;
  - on an hde falling edge, VGA_DE <= 0;
  - otherwise it holds.
  - BLANK_BLACK masking uses the DE value being written in the same cycle.
- Period 1 (cfg_len=0): every line uses sl_mask[0]; alternation has no effect.
- Reset asserted mid-frame: outputs 0 immediately. After release, DE stays 0 until the next hde rising edge. Dimming stays off until the next vsf.

Test Plan:
1. DW=8, vsf with sl_len=1, sl_mask=2'b10, sl_level=8; constant R=0xC8 → line 0 VGA_R=0xC8, line 1 VGA_R=0x64, line 2 VGA_R=0xC8; output appears 2 cycles after input.
2. Same setup with sl_level=4 → dark lines 0x96. With sl_level=15 → 0x0C. With sl_level=0 → 0xC8 on every line.
3. DW=4: R=0xA, mono=0 → VGA_R=0xAA. Then mono=1, G=0x3, R=0xC → VGA_R=VGA_G=VGA_B=0x3C.
4. sl_alternate=1, sl_len=1, sl_mask=2'b10 → frame A darkens odd lines, frame B darkens even lines. Change sl_mask to 2'b01 mid-frame → no change until the next VSync falling edge.
5. HSync and VSync falling on the same cycle → line_idx equals the start phase, not start+1. sl_len=2, mask=3'b100 → every third line is dark.
6. Assert reset mid-line with DE=1 → all outputs 0 asynchronously. After release, VGA_DE rises only at the next HBlank falling edge with VBlank=0. With BLANK_BLACK=1, RGB stays 0 while DE=0.
